// File: rtl/bp_dram_link_responder.sv
// bp_dram_link_responder: wormhole mem-NoC endpoint backed by a flop-array word memory.
// Accepts one command packet, then returns one response packet; receive and transmit never overlap.
module bp_dram_link_responder #(
  parameter int flit_width_p = 64,
  parameter int cord_width_p = 8,
  parameter int len_width_p  = 4,
  parameter int els_p        = 256,
  localparam int link_width_lp = flit_width_p + 2
) (
  input  logic                     clk_i,
  input  logic                     async_reset_n_i,
  input  logic [cord_width_p-1:0]  my_cord_i,
  input  logic [link_width_lp-1:0] cmd_link_i,
  output logic [link_width_lp-1:0] cmd_link_o
);
  localparam int len_lsb   = cord_width_p;
  localparam int op_lsb    = len_lsb + len_width_p;
  localparam int src_lsb   = op_lsb + 2;
  localparam int beats_lsb = src_lsb + cord_width_p;
  localparam int addr_lsb  = beats_lsb + len_width_p;
  localparam int addr_w    = flit_width_p - addr_lsb;
  localparam int idx_w     = $clog2(els_p);
  typedef enum logic [1:0] {RX_HDR, RX_DATA, TX_HDR, TX_DATA} state_e;
  state_e state, state_n;
  logic [cord_width_p-1:0] src;
  logic [1:0] op;
  logic [addr_w-1:0] addr;
  logic [len_width_p-1:0] beats, cnt, rlen;
  logic [idx_w-1:0] ptr;
  logic [flit_width_p-1:0] mem [els_p];
  logic in_v, out_rdy, cmd_rdy, out_v, unused_ok;
  logic [flit_width_p-1:0] in_data, out_data, resp_hdr;
  assign in_v      = cmd_link_i[link_width_lp-1];
  assign in_data   = cmd_link_i[flit_width_p:1];
  assign out_rdy   = cmd_link_i[0];
  assign unused_ok = ^in_data[cord_width_p-1:0];
  // only reads carry data back; writes and reserved opcodes get a bare ack
  assign rlen      = op == 2'b00 ? beats : '0;
  assign resp_hdr  = {addr, beats, my_cord_i, op, rlen, src};
  always_comb begin
    state_n  = state;
    cmd_rdy  = 1'b0;
    out_v    = 1'b0;
    out_data = '0;
    case (state)
      RX_HDR: begin
        cmd_rdy = 1'b1;
        if (in_v) state_n = in_data[len_lsb +: len_width_p] != '0 ? RX_DATA : TX_HDR;
      end
      RX_DATA: begin
        cmd_rdy = 1'b1;
        if (in_v && cnt == 1) state_n = TX_HDR;
      end
      TX_HDR: begin
        out_v    = 1'b1;
        out_data = resp_hdr;
        if (out_rdy) state_n = rlen != '0 ? TX_DATA : RX_HDR;
      end
      TX_DATA: begin
        out_v    = 1'b1;
        out_data = mem[ptr];
        if (out_rdy && cnt == 1) state_n = RX_HDR;
      end
    endcase
  end
  always_ff @(posedge clk_i or negedge async_reset_n_i) begin
    if (!async_reset_n_i) begin
      state <= RX_HDR;
      src   <= '0;
      op    <= '0;
      addr  <= '0;
      beats <= '0;
      cnt   <= '0;
      ptr   <= '0;
    end else begin
      state <= state_n;
      if (state == RX_HDR && in_v) begin
        src   <= in_data[src_lsb +: cord_width_p];
        op    <= in_data[op_lsb +: 2];
        addr  <= in_data[addr_lsb +: addr_w];
        beats <= in_data[beats_lsb +: len_width_p];
        cnt   <= in_data[len_lsb +: len_width_p];
        ptr   <= in_data[addr_lsb +: idx_w];
      end else if ((state == RX_DATA && in_v) || (state == TX_DATA && out_rdy)) begin
        ptr <= ptr + 1'b1;
        cnt <= cnt - 1'b1;
      end else if (state == TX_HDR && out_rdy) begin
        cnt <= beats;
        ptr <= addr[idx_w-1:0];
      end
    end
  end
  // memory survives reset so a stand-in DRAM keeps its image across link resets
  always_ff @(posedge clk_i)
    if (state == RX_DATA && in_v && op == 2'b01) mem[ptr] <= in_data;
  assign cmd_link_o = async_reset_n_i ? {out_v, out_data, cmd_rdy} : '0;
endmodule

// File: tb/tb_bp_dram_link_responder.sv
// tb_bp_dram_link_responder: directed scenarios with hand-computed expected flits.
module tb_bp_dram_link_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] my_cord = 8'h05;
  logic cmd_v = 1'b0;
  logic [63:0] cmd_data = '0;
  logic resp_rdy = 1'b0;
  logic [65:0] link_i, link_o;
  logic o_v, o_rdy;
  logic [63:0] o_data;
  int total = 0, bad = 0;
  assign link_i = {cmd_v, cmd_data, resp_rdy};
  assign o_v    = link_o[65];
  assign o_data = link_o[64:1];
  assign o_rdy  = link_o[0];
  always #5 clk = ~clk;
  bp_dram_link_responder dut (
    .clk_i(clk), .async_reset_n_i(rst_n), .my_cord_i(my_cord),
    .cmd_link_i(link_i), .cmd_link_o(link_o)
  );
  function automatic logic [63:0] hdr(input logic [7:0] c, input logic [3:0] l, input logic [1:0] op,
                                      input logic [7:0] s, input logic [3:0] b, input logic [37:0] a);
    return {a, b, s, op, l, c};
  endfunction
  task automatic send_flit(input logic [63:0] d);
    int n = 0;
    @(negedge clk);
    cmd_v = 1'b1;
    cmd_data = d;
    #1;
    while (!o_rdy && n < 50) begin @(negedge clk); #1; n++; end
    if (!o_rdy) begin total++; bad++; $display("FAIL send_timeout ready=%b need=1", o_rdy); end
    @(posedge clk);
    #1 cmd_v = 1'b0;
  endtask
  task automatic recv_flit(output logic [63:0] d);
    int n = 0;
    @(negedge clk);
    resp_rdy = 1'b1;
    #1;
    while (!o_v && n < 50) begin @(negedge clk); #1; n++; end
    d = o_v ? o_data : 'x;
    @(posedge clk);
    #1 resp_rdy = 1'b0;
  endtask
  task automatic test_reset;
    logic seen = 1'b0;
    cmd_v = 1'b1;
    cmd_data = hdr(8'h0, 4'd0, 2'b00, 8'h21, 4'd0, 38'h10);
    resp_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      total++;
      if (link_o !== '0) begin bad++; $display("FAIL reset_out cyc=%0d got=%h exp=0", i, link_o); end
    end
    @(negedge clk);
    cmd_v = 1'b0;
    rst_n = 1'b1;
    #1;
    total++;
    if (o_rdy !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", o_rdy); end
    for (int i = 0; i < 3; i++) begin @(negedge clk); #1; seen = seen | (o_v !== 1'b0); end
    total++;
    if (seen) begin bad++; $display("FAIL reset_no_resp got=1 exp=0"); end
    resp_rdy = 1'b0;
  endtask
  task automatic test_write_read;
    logic [63:0] d;
    send_flit(hdr(8'h0, 4'd2, 2'b01, 8'h21, 4'd2, 38'h10));
    send_flit(64'hA);
    send_flit(64'hB);
    recv_flit(d);
    total++;
    if (d !== hdr(8'h21, 4'd0, 2'b01, 8'h05, 4'd2, 38'h10)) begin bad++; $display("FAIL wr_ack got=%h exp=%h", d, hdr(8'h21, 4'd0, 2'b01, 8'h05, 4'd2, 38'h10)); end
    send_flit(hdr(8'h0, 4'd0, 2'b00, 8'h21, 4'd2, 38'h10));
    recv_flit(d);
    total++;
    if (d !== hdr(8'h21, 4'd2, 2'b00, 8'h05, 4'd2, 38'h10)) begin bad++; $display("FAIL rd_hdr got=%h exp=%h", d, hdr(8'h21, 4'd2, 2'b00, 8'h05, 4'd2, 38'h10)); end
    recv_flit(d);
    total++;
    if (d !== 64'hA) begin bad++; $display("FAIL rd_d0 got=%h exp=a", d); end
    recv_flit(d);
    total++;
    if (d !== 64'hB) begin bad++; $display("FAIL rd_d1 got=%h exp=b", d); end
    @(negedge clk); #1;
    total++;
    if (o_v !== 1'b0 || o_rdy !== 1'b1) begin bad++; $display("FAIL rd_idle v=%b rdy=%b exp v=0 rdy=1", o_v, o_rdy); end
  endtask
  task automatic test_header_only;
    logic [63:0] d;
    send_flit(hdr(8'h0, 4'd0, 2'b00, 8'h33, 4'd0, 38'h10));
    total++;
    if (o_v !== 1'b1 || o_rdy !== 1'b0) begin bad++; $display("FAIL hdr_latency v=%b rdy=%b exp v=1 rdy=0", o_v, o_rdy); end
    recv_flit(d);
    total++;
    if (d !== hdr(8'h33, 4'd0, 2'b00, 8'h05, 4'd0, 38'h10)) begin bad++; $display("FAIL hdr_only got=%h exp=%h", d, hdr(8'h33, 4'd0, 2'b00, 8'h05, 4'd0, 38'h10)); end
    @(negedge clk); #1;
    total++;
    if (o_v !== 1'b0) begin bad++; $display("FAIL hdr_only_extra got=%b exp=0", o_v); end
  endtask
  task automatic test_wrap;
    logic [63:0] d;
    send_flit(hdr(8'h0, 4'd2, 2'b01, 8'h21, 4'd2, 38'hFF));
    send_flit(64'h1);
    send_flit(64'h2);
    recv_flit(d);
    total++;
    if (d !== hdr(8'h21, 4'd0, 2'b01, 8'h05, 4'd2, 38'hFF)) begin bad++; $display("FAIL wrap_ack got=%h", d); end
    send_flit(hdr(8'h0, 4'd0, 2'b00, 8'h21, 4'd2, 38'hFF));
    recv_flit(d);
    total++;
    if (d !== hdr(8'h21, 4'd2, 2'b00, 8'h05, 4'd2, 38'hFF)) begin bad++; $display("FAIL wrap_hdr got=%h", d); end
    recv_flit(d);
    total++;
    if (d !== 64'h1) begin bad++; $display("FAIL wrap_d0 got=%h exp=1", d); end
    recv_flit(d);
    total++;
    if (d !== 64'h2) begin bad++; $display("FAIL wrap_d1 got=%h exp=2", d); end
    send_flit(hdr(8'h0, 4'd0, 2'b00, 8'h21, 4'd1, 38'h300));
    recv_flit(d);
    total++;
    if (d !== hdr(8'h21, 4'd1, 2'b00, 8'h05, 4'd1, 38'h300)) begin bad++; $display("FAIL upper_hdr got=%h", d); end
    recv_flit(d);
    total++;
    if (d !== 64'h2) begin bad++; $display("FAIL upper_d0 got=%h exp=2", d); end
  endtask
  task automatic test_backpressure;
    logic [63:0] d, prev;
    logic [63:0] got [5];
    logic [63:0] exp [5];
    logic [3:0] pat = 4'b1001;
    logic stalled = 1'b0;
    int n = 0, stab_bad = 0, rdy_bad = 0;
    exp = '{hdr(8'h21, 4'd4, 2'b00, 8'h05, 4'd4, 38'h40), 64'h11, 64'h22, 64'h33, 64'h44};
    for (int i = 0; i < 5; i++) got[i] = 'x;
    send_flit(hdr(8'h0, 4'd4, 2'b01, 8'h21, 4'd4, 38'h40));
    send_flit(64'h11);
    send_flit(64'h22);
    send_flit(64'h33);
    send_flit(64'h44);
    recv_flit(d);
    total++;
    if (d !== hdr(8'h21, 4'd0, 2'b01, 8'h05, 4'd4, 38'h40)) begin bad++; $display("FAIL bp_wr_ack got=%h", d); end
    send_flit(hdr(8'h0, 4'd0, 2'b00, 8'h21, 4'd4, 38'h40));
    prev = '0;
    for (int c = 0; c < 40 && n < 5; c++) begin
      @(negedge clk);
      resp_rdy = pat[c % 4];
      #1;
      if (stalled && (o_v !== 1'b1 || o_data !== prev)) stab_bad++;
      if (o_v && o_rdy !== 1'b0) rdy_bad++;
      if (o_v && resp_rdy) begin got[n] = o_data; n++; end
      stalled = o_v && !resp_rdy;
      prev = o_data;
    end
    @(posedge clk);
    #1 resp_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (got[i] !== exp[i]) begin bad++; $display("FAIL bp_flit%0d got=%h exp=%h", i, got[i], exp[i]); end
    end
    total++;
    if (stab_bad != 0) begin bad++; $display("FAIL bp_stable got=%0d exp=0", stab_bad); end
    total++;
    if (rdy_bad != 0) begin bad++; $display("FAIL bp_cmd_ready got=%0d exp=0", rdy_bad); end
    @(negedge clk); #1;
    total++;
    if (o_v !== 1'b0) begin bad++; $display("FAIL bp_extra got=%b exp=0", o_v); end
  endtask
  task automatic test_reserved;
    logic [63:0] d;
    send_flit(hdr(8'h0, 4'd3, 2'b10, 8'h21, 4'd3, 38'h40));
    for (int i = 0; i < 3; i++) send_flit(64'hDEAD);
    recv_flit(d);
    total++;
    if (d !== hdr(8'h21, 4'd0, 2'b10, 8'h05, 4'd3, 38'h40)) begin bad++; $display("FAIL rsv_ack got=%h", d); end
    send_flit(hdr(8'h0, 4'd0, 2'b00, 8'h21, 4'd3, 38'h40));
    recv_flit(d);
    total++;
    if (d !== hdr(8'h21, 4'd3, 2'b00, 8'h05, 4'd3, 38'h40)) begin bad++; $display("FAIL rsv_rd_hdr got=%h", d); end
    for (int i = 0; i < 3; i++) begin
      recv_flit(d);
      total++;
      if (d !== 64'h11 * (i + 1)) begin bad++; $display("FAIL rsv_rd%0d got=%h exp=%h", i, d, 64'h11 * (i + 1)); end
    end
  endtask
  task automatic test_reset_mid;
    logic [63:0] d;
    logic seen = 1'b0;
    send_flit(hdr(8'h0, 4'd3, 2'b01, 8'h21, 4'd3, 38'h40));
    send_flit(64'h99);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (link_o !== '0) begin bad++; $display("FAIL mid_reset_out got=%h exp=0", link_o); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    resp_rdy = 1'b1;
    #1;
    total++;
    if (o_rdy !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b exp=1", o_rdy); end
    for (int i = 0; i < 4; i++) begin @(negedge clk); #1; seen = seen | (o_v !== 1'b0); end
    resp_rdy = 1'b0;
    total++;
    if (seen) begin bad++; $display("FAIL mid_no_resp got=1 exp=0"); end
    send_flit(hdr(8'h0, 4'd0, 2'b00, 8'h44, 4'd3, 38'h40));
    recv_flit(d);
    total++;
    if (d !== hdr(8'h44, 4'd3, 2'b00, 8'h05, 4'd3, 38'h40)) begin bad++; $display("FAIL mid_rd_hdr got=%h", d); end
    recv_flit(d);
    total++;
    if (d !== 64'h99) begin bad++; $display("FAIL mid_rd0 got=%h exp=99", d); end
    recv_flit(d);
    total++;
    if (d !== 64'h22) begin bad++; $display("FAIL mid_rd1 got=%h exp=22", d); end
    recv_flit(d);
    total++;
    if (d !== 64'h33) begin bad++; $display("FAIL mid_rd2 got=%h exp=33", d); end
  endtask
  initial begin
    test_reset;
    test_write_read;
    test_header_only;
    test_wrap;
    test_backpressure;
    test_reserved;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
